// File: rtl/mem_access_stage.sv
// MEM stage of the RV32 pipeline: data-memory load/store against an internal
// word RAM, branch/jump resolution with PC redirect and flush, forwarding
// taps, and the MEM/WB pipeline register.
module mem_access_stage #(
    parameter int DMEM_WORDS = 256,
    parameter int DMEM_AW    = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        Ctl_MemtoReg_in,
    input  logic        Ctl_RegWrite_in,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic        Ctl_branch_in,
    input  logic        jal_in,
    input  logic        jalr_in,
    input  logic        Zero_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  Rd_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] PCimm_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] PC_in,

    output logic [31:0] mem_data,
    output logic [4:0]  mem_Rd_out,
    output logic        mem_Ctl_RegWrite_out,

    output logic        PCSrc_out,
    output logic [31:0] PCtarget_out,
    output logic        flush_out,

    output logic        Ctl_MemtoReg_out,
    output logic        Ctl_RegWrite_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUresult_out
);

    localparam logic [2:0] F3_BYTE  = 3'b000;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam logic [2:0] F3_BYTEU = 3'b100;
    localparam logic [2:0] F3_BEQ   = 3'b000;
    localparam logic [2:0] F3_BNE   = 3'b001;
    localparam logic [2:0] F3_BLT   = 3'b100;
    localparam logic [2:0] F3_BGE   = 3'b101;

    // Data RAM; deliberately not cleared by reset.
    logic [31:0] dmem [DMEM_WORDS];

    logic [DMEM_AW-1:0] word_idx;
    logic [1:0]         byte_lane;
    logic [31:0]        rd_word;
    logic [7:0]         sel_byte;
    logic [31:0]        load_value;
    logic               wr_en;
    logic [31:0]        wr_word;
    logic               branch_taken;
    logic               redirect;

    // Upper address bits are dropped so accesses wrap modulo the RAM depth.
    assign word_idx  = ALUresult_in[DMEM_AW+1:2];
    assign byte_lane = ALUresult_in[1:0];
    assign rd_word   = dmem[word_idx];

    // Forwarding taps straight from the EX/MEM register.
    assign mem_data             = ALUresult_in;
    assign mem_Rd_out           = Rd_in;
    assign mem_Ctl_RegWrite_out = Ctl_RegWrite_in;

    // Pick the addressed byte out of the current word.
    always_comb begin
        sel_byte = rd_word[7:0];
        case (byte_lane)
            2'd0: sel_byte = rd_word[7:0];
            2'd1: sel_byte = rd_word[15:8];
            2'd2: sel_byte = rd_word[23:16];
            2'd3: sel_byte = rd_word[31:24];
            default: sel_byte = rd_word[7:0];
        endcase
    end

    // Format load data by width; unsupported widths and non-loads return 0.
    always_comb begin
        load_value = 32'd0;
        if (Ctl_MemRead_in) begin
            case (funct3_in)
                F3_BYTE:  load_value = {{24{sel_byte[7]}}, sel_byte};
                F3_BYTEU: load_value = {24'd0, sel_byte};
                F3_WORD:  load_value = rd_word;
                default:  load_value = 32'd0;
            endcase
        end
    end

    // Build the word to write back: byte stores merge into the old word.
    always_comb begin
        wr_en   = 1'b0;
        wr_word = rd_word;
        case (funct3_in)
            F3_BYTE: begin
                wr_en = 1'b1;
                case (byte_lane)
                    2'd0: wr_word[7:0]   = ReadData2_in[7:0];
                    2'd1: wr_word[15:8]  = ReadData2_in[7:0];
                    2'd2: wr_word[23:16] = ReadData2_in[7:0];
                    2'd3: wr_word[31:24] = ReadData2_in[7:0];
                    default: wr_word     = rd_word;
                endcase
            end
            F3_WORD: begin
                wr_en   = 1'b1;
                wr_word = ReadData2_in;
            end
            default: begin
                wr_en   = 1'b0;
                wr_word = rd_word;
            end
        endcase
    end

    // Commit stores; a reset cycle suppresses the write but keeps contents.
    always_ff @(posedge clk) begin
        if (!reset && Ctl_MemWrite_in && wr_en) begin
            dmem[word_idx] <= wr_word;
        end
    end

    // Branch condition from the ALU zero flag; blt/bge rely on the EX stage
    // having produced a zero flag that already encodes the comparison.
    always_comb begin
        branch_taken = 1'b0;
        if (Ctl_branch_in) begin
            case (funct3_in)
                F3_BEQ:  branch_taken = Zero_in;
                F3_BNE,
                F3_BLT,
                F3_BGE:  branch_taken = ~Zero_in;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    // Redirect request and target; jalr wins over jal and clears bit 0.
    always_comb begin
        redirect     = branch_taken | jal_in | jalr_in;
        PCtarget_out = PCimm_in;
        if (jalr_in) begin
            PCtarget_out = {ALUresult_in[31:1], 1'b0};
        end
    end

    assign PCSrc_out = redirect;
    assign flush_out = redirect;

    // MEM/WB pipeline register; jumps write back the link address.
    always_ff @(posedge clk) begin
        if (reset) begin
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Rd_out           <= 5'd0;
            ReadData_out     <= 32'd0;
            ALUresult_out    <= 32'd0;
        end else begin
            Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
            Ctl_RegWrite_out <= Ctl_RegWrite_in;
            Rd_out           <= Rd_in;
            ReadData_out     <= load_value;
            ALUresult_out    <= (jal_in || jalr_in) ? (PC_in + 32'd4) : ALUresult_in;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: stimulus pushes model expectations into a
// queue, an independent monitor pops one per clock and compares.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in;
    logic        Ctl_branch_in, jal_in, jalr_in, Zero_in;
    logic [2:0]  funct3_in;
    logic [4:0]  Rd_in;
    logic [31:0] ALUresult_in, PCimm_in, ReadData2_in, PC_in;
    logic [31:0] mem_data;
    logic [4:0]  mem_Rd_out;
    logic        mem_Ctl_RegWrite_out;
    logic        PCSrc_out;
    logic [31:0] PCtarget_out;
    logic        flush_out;
    logic        Ctl_MemtoReg_out, Ctl_RegWrite_out;
    logic [4:0]  Rd_out;
    logic [31:0] ReadData_out, ALUresult_out;

    mem_access_stage #(.DMEM_WORDS(256), .DMEM_AW(8)) dut (
        .clk(clk), .reset(reset),
        .Ctl_MemtoReg_in(Ctl_MemtoReg_in), .Ctl_RegWrite_in(Ctl_RegWrite_in),
        .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in),
        .Ctl_branch_in(Ctl_branch_in), .jal_in(jal_in), .jalr_in(jalr_in),
        .Zero_in(Zero_in), .funct3_in(funct3_in), .Rd_in(Rd_in),
        .ALUresult_in(ALUresult_in), .PCimm_in(PCimm_in),
        .ReadData2_in(ReadData2_in), .PC_in(PC_in),
        .mem_data(mem_data), .mem_Rd_out(mem_Rd_out),
        .mem_Ctl_RegWrite_out(mem_Ctl_RegWrite_out),
        .PCSrc_out(PCSrc_out), .PCtarget_out(PCtarget_out), .flush_out(flush_out),
        .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
        .Rd_out(Rd_out), .ReadData_out(ReadData_out), .ALUresult_out(ALUresult_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd_c;
        logic        rw_c;
        logic        pcsrc;
        logic [31:0] target;
        logic        mtr;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] ld;
        logic [31:0] alu;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  dm [1024];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: registered outputs have just captured, inputs are still held.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("mem_data", mem_data, e.data);
                chk("mem_Rd_out", {27'd0, mem_Rd_out}, {27'd0, e.rd_c});
                chk("mem_RegWrite", {31'd0, mem_Ctl_RegWrite_out}, {31'd0, e.rw_c});
                chk("PCSrc", {31'd0, PCSrc_out}, {31'd0, e.pcsrc});
                chk("PCtarget", PCtarget_out, e.target);
                chk("flush", {31'd0, flush_out}, {31'd0, e.pcsrc});
                chk("MemtoReg_out", {31'd0, Ctl_MemtoReg_out}, {31'd0, e.mtr});
                chk("RegWrite_out", {31'd0, Ctl_RegWrite_out}, {31'd0, e.rw});
                chk("Rd_out", {27'd0, Rd_out}, {27'd0, e.rd});
                chk("ReadData_out", ReadData_out, e.ld);
                chk("ALUresult_out", ALUresult_out, e.alu);
            end
        end
    end

    // Drive one instruction, predict its outcome from a byte-addressed model,
    // then wait for the next falling edge.
    task automatic step(input logic rst, input logic mtr, input logic rw,
                        input logic mr, input logic mw, input logic br,
                        input logic jl, input logic jr, input logic zero,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] pcimm,
                        input logic [31:0] rd2, input logic [31:0] pc);
        exp_t        e;
        int          base;
        int          lane;
        logic [31:0] word;
        logic [7:0]  b;
        logic        taken;
        reset = rst; Ctl_MemtoReg_in = mtr; Ctl_RegWrite_in = rw;
        Ctl_MemRead_in = mr; Ctl_MemWrite_in = mw; Ctl_branch_in = br;
        jal_in = jl; jalr_in = jr; Zero_in = zero; funct3_in = f3; Rd_in = rd;
        ALUresult_in = alu; PCimm_in = pcimm; ReadData2_in = rd2; PC_in = pc;

        base = ((alu / 4) % 256) * 4;
        lane = alu % 4;
        word = {dm[base+3], dm[base+2], dm[base+1], dm[base]};
        b    = dm[base+lane];

        e.data = alu; e.rd_c = rd; e.rw_c = rw;
        taken = br && ((f3 == 3'd0 && zero) ||
                       ((f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5) && !zero));
        e.pcsrc  = taken || jl || jr;
        e.target = jr ? (alu & 32'hFFFF_FFFE) : pcimm;
        if (rst) begin
            e.mtr = 0; e.rw = 0; e.rd = 0; e.ld = 0; e.alu = 0;
        end else begin
            e.mtr = mtr; e.rw = rw; e.rd = rd;
            e.alu = (jl || jr) ? pc + 32'd4 : alu;
            e.ld  = 32'd0;
            if (mr) begin
                if (f3 == 3'd0)      e.ld = {{24{b[7]}}, b};
                else if (f3 == 3'd4) e.ld = {24'd0, b};
                else if (f3 == 3'd2) e.ld = word;
            end
            if (mw && f3 == 3'd2) begin
                dm[base]   = rd2[7:0];   dm[base+1] = rd2[15:8];
                dm[base+2] = rd2[23:16]; dm[base+3] = rd2[31:24];
            end else if (mw && f3 == 3'd0) begin
                dm[base+lane] = rd2[7:0];
            end
        end
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0,0,0,0,0,0,0,0,0,3'd0,5'd0,32'd0,32'd0,32'd0,32'd0);
    endtask
    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        step(0,0,0,0,1,0,0,0,0,3'd2,5'd0,a,32'd0,d,32'd0);
    endtask
    task automatic sb(input logic [31:0] a, input logic [31:0] d);
        step(0,0,0,0,1,0,0,0,0,3'd0,5'd0,a,32'd0,d,32'd0);
    endtask
    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
        step(0,1,1,1,0,0,0,0,0,f3,rd,a,32'd0,32'd0,32'd0);
    endtask
    task automatic bra(input logic [2:0] f3, input logic br, input logic zero);
        step(0,0,0,0,0,br,0,0,zero,f3,5'd0,32'd0,32'h80,32'd0,32'h10);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a;
        int          op;
        int          waited;
        step(1,0,0,0,0,0,0,0,0,3'd0,5'd0,32'd0,32'd0,32'd0,32'd0);
        step(1,1,1,1,0,1,1,0,1,3'd2,5'd7,32'h55,32'h66,32'h77,32'h88);

        for (int i = 0; i < 256; i++) sw(i * 4, $urandom);

        sw(32'h10, 32'hDEADBEEF);
        ld(3'd2, 32'h10, 5'd3);
        idle();

        sw(32'h20, 32'h11223344);
        sb(32'h21, 32'h000000F0);
        ld(3'd0, 32'h21, 5'd4);
        ld(3'd4, 32'h21, 5'd5);
        ld(3'd2, 32'h20, 5'd6);

        sw(32'h400, 32'hCAFEF00D);
        ld(3'd2, 32'h000, 5'd7);

        bra(3'd0, 1, 1); bra(3'd0, 1, 0);
        bra(3'd1, 1, 0); bra(3'd4, 1, 0); bra(3'd5, 1, 0);
        bra(3'd1, 1, 1); bra(3'd2, 1, 0); bra(3'd0, 0, 1);

        step(0,0,1,0,0,0,0,1,0,3'd0,5'd1,32'h103,32'h999,32'd0,32'h40);
        step(0,0,1,0,0,0,1,0,0,3'd0,5'd1,32'h55,32'h200,32'd0,32'h60);
        step(0,0,1,0,0,0,1,1,0,3'd0,5'd2,32'h301,32'h200,32'd0,32'h70);

        sw(32'h30, 32'h12345678);
        step(1,0,0,0,1,0,0,0,0,3'd2,5'd0,32'h30,32'd0,32'h5,32'd0);
        ld(3'd2, 32'h30, 5'd8);
        step(0,1,1,1,1,0,0,0,0,3'd2,5'd9,32'h30,32'd0,32'hABCD0123,32'd0);
        ld(3'd2, 32'h30, 5'd9);

        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 5);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0: f3 = 3'd0;
                1: f3 = 3'd2;
                2: f3 = 3'd4;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            step(($urandom_range(0, 24) == 0),
                 1'($urandom), 1'($urandom),
                 (op == 0 || op == 5), (op == 1 || op == 5),
                 (op == 2), (op == 3), (op == 4 || ($urandom_range(0, 9) == 0)),
                 1'($urandom), f3, 5'($urandom), a, $urandom, $urandom, $urandom);
        end
        idle();

        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RV32 pipeline; consumes the EX/MEM register contents driven by the execution stage.
- Performs data-memory load/store against an internal synchronous word RAM.
- Resolves branch/jal/jalr into a PC redirect plus a flush to the front end.
- Feeds the forwarding path (mem_data, mem_Rd, mem_Ctl_RegWrite).
- Registers the MEM/WB pipeline register for writeback.

Parameters:
- DMEM_WORDS, 256, depth of data RAM in 32-bit words; must be a power of two.
- DMEM_AW, 8, word-index width, log2(DMEM_WORDS).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_branch_in  in  1 each  EX/MEM control bits.
- jal_in, jalr_in  in  1 each  jump flags.
- Zero_in  in  1  ALU zero flag.
- funct3_in  in  3  instruction funct3, used for load/store width and branch type.
- Rd_in  in  5  destination register.
- ALUresult_in, PCimm_in, ReadData2_in, PC_in  in  32 each  address/result, branch target, store data, instruction PC.
- mem_data  out  32  forwarding value = ALUresult_in, combinational.
- mem_Rd_out  out  5  = Rd_in, combinational.
- mem_Ctl_RegWrite_out  out  1  = Ctl_RegWrite_in, combinational.
- PCSrc_out  out  1  redirect request, combinational.
- PCtarget_out  out  32  redirect address, combinational.
- flush_out  out  1  = PCSrc_out.
- Ctl_MemtoReg_out, Ctl_RegWrite_out  out  1 each  MEM/WB registered.
- Rd_out  out  5  MEM/WB registered.
- ReadData_out, ALUresult_out  out  32 each  MEM/WB registered; ALUresult_out carries PC_in+4 for jal/jalr.

Behaviour:
- Addressing: byte address = ALUresult_in. Word index = ALUresult_in[DMEM_AW+1:2], wrapping modulo DMEM_WORDS; upper bits are ignored. Byte lane = ALUresult_in[1:0].
- Store, on posedge clk when Ctl_MemWrite_in=1 and reset=0:
  - funct3=000 (sb): write ReadData2_in[7:0] into the selected byte lane only.
  - funct3=010 (sw): write the full word; ALUresult_in[1:0] is ignored.
  - Any other funct3: no write.
- Load, on posedge clk when Ctl_MemRead_in=1:
  - The RAM word is read and formatted; the result is registered into ReadData_out.
  - Load latency is one cycle: data is visible in MEM/WB the cycle after the instruction occupies MEM.
  - funct3=000 (lb): selected byte, sign-extended. 100 (lbu): zero-extended. 010 (lw): full word. Other funct3: 0.
- When Ctl_MemRead_in=0, ReadData_out loads 0.
- Read-during-write: a single instruction never does both. If both bits are set, the write commits and ReadData_out returns the old word.
- Branch resolution is combinational from inputs, with Ctl_branch_in=1:
  - funct3=000 (beq): taken if Zero_in=1.
  - 001 (bne), 100 (blt), 101 (bge): taken if Zero_in=0.
  - Other funct3: not taken.
- PC redirect:
  - PCSrc_out = branch_taken | jal_in | jalr_in.
  - PCtarget_out = jalr_in ? {ALUresult_in[31:1],1'b0} : PCimm_in. jalr takes priority if jal_in and jalr_in are both set.
  - When PCSrc_out=0, PCtarget_out = PCimm_in (don't-care, but deterministic).
- flush_out equals PCSrc_out in the same cycle. The upstream ID/EX and EX/MEM flush inputs consume it.
- MEM/WB register, on posedge clk:
  - If reset: Ctl_MemtoReg_out=0, Ctl_RegWrite_out=0, Rd_out=0, ReadData_out=0, ALUresult_out=0, and no RAM write occurs.
  - Else: controls and Rd_in pass through. ALUresult_out = (jal_in|jalr_in) ? PC_in+4 : ALUresult_in.
- Writes to Rd=0 are not suppressed here; the register file masks x0.
- RAM contents are not cleared by reset. A reset asserted mid-stream blocks only that cycle's store.
- Reset outputs: all registered outputs are 0. Combinational outputs follow the inputs, which are 0 from an upstream reset.

Test Plan:
- sw then lw: sw ALUresult=0x10, ReadData2=0xDEADBEEF; next cycle lw 0x10 -> ReadData_out=0xDEADBEEF one cycle later, Ctl_MemtoReg_out=1.
- Byte lanes: sw 0x20 ← 0x11223344; sb 0x21 ← 0x000000F0; then lb 0x21 -> 0xFFFFFFF0, lbu 0x21 -> 0x000000F0, lw 0x20 -> 0x1122F044.
- Address wrap: sw to 0x400 with DMEM_WORDS=256 -> lw 0x000 returns the stored value.
- Branches, PCimm=0x80: beq Zero=1 -> PCSrc=1, target 0x80, flush=1. beq Zero=0 -> PCSrc=0. bne/blt/bge Zero=0 -> PCSrc=1. Ctl_branch=0 with Zero=1 -> PCSrc=0.
- jal/jalr: jalr ALUresult=0x103, PC=0x40, Rd=1 -> PCtarget=0x102, next cycle ALUresult_out=0x44, Rd_out=1. jal PCimm=0x200 -> PCtarget=0x200.
- Reset mid-op: assert reset on the same cycle as sw 0x30 ← 0x5 -> all registered outputs are 0 and a later lw 0x30 returns the prior contents. Forwarding outputs mirror inputs in every cycle.
